bin_to_bcd_stream: RTL and testbench



---
 rtl/bin_to_bcd_stream.sv | 168 ++++++++++++++++
 tb/tb_bin_to_bcd_stream.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_stream.sv
// bin_to_bcd_stream: handshaked binary-to-BCD converter.
// It uses iterative double-dabble and consumes one input bit per clock.
// Optional signed mode converts the magnitude and reports the sign.
// A sticky overflow saturates the result to all nines.
// digitsUsed supports leading-zero blanking downstream.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   inValid        binaryNumber is valid
//   inReady        block can accept a word (registered)
//   binaryNumber   W-bit value to convert
//   outValid       result is valid (registered)
//   outReady       downstream accepts the result
//   BinaryDecimal  D BCD digits; digit 0 is least significant
//   negative       input was negative (signedMode only)
//   overflow       magnitude >= 10^D, BinaryDecimal saturated
//   digitsUsed     index of the most significant non-zero digit + 1; 1 for zero
module bin_to_bcd_stream #(
    parameter int unsigned binaryNumberWidth = 32,
    parameter int unsigned numberOfDigits    = 10,
    parameter int unsigned signedMode        = 0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       inValid,
    output logic                                       inReady,
    input  logic [binaryNumberWidth-1:0]               binaryNumber,
    output logic                                       outValid,
    input  logic                                       outReady,
    output logic [numberOfDigits-1:0][3:0]             BinaryDecimal,
    output logic                                       negative,
    output logic                                       overflow,
    output logic [$clog2(numberOfDigits+1)-1:0]        digitsUsed
);

    localparam int unsigned W  = binaryNumberWidth;
    localparam int unsigned D  = numberOfDigits;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned UW = $clog2(D + 1);
    localparam int unsigned SW = 4 * D + W;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [W-1:0]           mag;
    logic [D-1:0][3:0]      bcd;
    logic                   ovf_acc;
    logic                   sign;
    logic [CW-1:0]          cnt;

    logic                   accept;
    logic                   last_shift;
    logic [W-1:0]           in_mag;
    logic [D-1:0][3:0]      bcd_adj;
    logic [SW-1:0]          shifted;
    logic [D-1:0][3:0]      bcd_shift;
    logic [W-1:0]           mag_shift;
    logic                   ovf_next;
    logic [D-1:0][3:0]      result;
    logic [UW-1:0]          used;

    assign accept     = inValid && inReady;
    assign last_shift = (cnt == CW'(W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = CONVERT;
            CONVERT: if (last_shift) state_next = DONE;
            DONE:    if (outReady)   state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Magnitude of the incoming word; the most negative value maps to 2^(W-1)
    always_comb begin
        in_mag = binaryNumber;
        if ((signedMode != 0) && binaryNumber[W-1]) begin
            in_mag = (~binaryNumber) + W'(1);
        end
    end

    // One double-dabble step: add 3 to digits >= 5, then shift {bcd, mag} left
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(D); i++) begin
            if (bcd[i] >= 4'd5) begin
                bcd_adj[i] = bcd[i] + 4'd3;
            end
        end
        ovf_next  = ovf_acc | bcd_adj[D-1][3];
        shifted   = {bcd_adj, mag} << 1;
        bcd_shift = shifted[SW-1:W];
        mag_shift = shifted[W-1:0];
    end

    // Final result and significant-digit count for the value being published
    always_comb begin
        result = ovf_next ? {D{4'h9}} : bcd_shift;
        used   = UW'(1);
        for (int i = 0; i < int'(D); i++) begin
            if (result[i] != 4'h0) begin
                used = UW'(i + 1);
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag           <= '0;
            bcd           <= '0;
            ovf_acc       <= 1'b0;
            sign          <= 1'b0;
            cnt           <= '0;
            inReady       <= 1'b0;
            outValid      <= 1'b0;
            BinaryDecimal <= '0;
            negative      <= 1'b0;
            overflow      <= 1'b0;
            digitsUsed    <= '0;
        end else begin
            inReady  <= (state_next == IDLE);
            outValid <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        mag     <= in_mag;
                        sign    <= binaryNumber[W-1];
                        bcd     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= '0;
                    end
                end
                CONVERT: begin
                    mag     <= mag_shift;
                    bcd     <= bcd_shift;
                    ovf_acc <= ovf_next;
                    cnt     <= cnt + CW'(1);
                    if (last_shift) begin
                        BinaryDecimal <= result;
                        overflow      <= ovf_next;
                        negative      <= sign && (signedMode != 0);
                        digitsUsed    <= used;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// Directed self-checking bench for bin_to_bcd_stream.
// Instance a: defaults (W=32, D=10). Instance b: W=32, D=6 (overflow).
// Instance c: W=8, D=3, signed.
module tb_bin_to_bcd_stream;

    logic clk;
    logic rst_n;
    logic [2:0] in_valid;
    logic [2:0] out_ready;
    wire  [2:0] in_ready;
    wire  [2:0] out_valid;

    logic [31:0] bin_a;
    logic [31:0] bin_b;
    logic [7:0]  bin_c;

    logic [9:0][3:0] dec_a;
    logic [5:0][3:0] dec_b;
    logic [2:0][3:0] dec_c;
    logic neg_a, neg_b, neg_c;
    logic ovf_a, ovf_b, ovf_c;
    logic [3:0] used_a;
    logic [2:0] used_b;
    logic [1:0] used_c;

    int tests = 0;
    int fails = 0;

    bin_to_bcd_stream #(.binaryNumberWidth(32), .numberOfDigits(10), .signedMode(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .inValid(in_valid[0]), .inReady(in_ready[0]), .binaryNumber(bin_a),
        .outValid(out_valid[0]), .outReady(out_ready[0]),
        .BinaryDecimal(dec_a), .negative(neg_a), .overflow(ovf_a), .digitsUsed(used_a)
    );

    bin_to_bcd_stream #(.binaryNumberWidth(32), .numberOfDigits(6), .signedMode(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .inValid(in_valid[1]), .inReady(in_ready[1]), .binaryNumber(bin_b),
        .outValid(out_valid[1]), .outReady(out_ready[1]),
        .BinaryDecimal(dec_b), .negative(neg_b), .overflow(ovf_b), .digitsUsed(used_b)
    );

    bin_to_bcd_stream #(.binaryNumberWidth(8), .numberOfDigits(3), .signedMode(1)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .inValid(in_valid[2]), .inReady(in_ready[2]), .binaryNumber(bin_c),
        .outValid(out_valid[2]), .outReady(out_ready[2]),
        .BinaryDecimal(dec_c), .negative(neg_c), .overflow(ovf_c), .digitsUsed(used_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one word into instance sel and capture its result; lat = -1 on timeout
    task automatic convert(input int sel, input logic [31:0] val, output int lat,
                           output logic [39:0] bcd, output logic neg, output logic ovf,
                           output logic [3:0] used);
        int n;
        lat  = -1;
        bcd  = '0;
        neg  = 1'b0;
        ovf  = 1'b0;
        used = '0;
        @(negedge clk);
        n = 0;
        while (!in_ready[sel] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[sel]) return;
        case (sel)
            0:       bin_a = val;
            1:       bin_b = val;
            default: bin_c = val[7:0];
        endcase
        in_valid[sel] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        n = 0;
        while (!out_valid[sel] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid[sel]) return;
        lat = n;
        case (sel)
            0: begin
                bcd = 40'(dec_a); neg = neg_a; ovf = ovf_a; used = 4'(used_a);
            end
            1: begin
                bcd = 40'(dec_b); neg = neg_b; ovf = ovf_b; used = 4'(used_b);
            end
            default: begin
                bcd = 40'(dec_c); neg = neg_c; ovf = ovf_c; used = 4'(used_c);
            end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dec_a !== 40'h0 || out_valid[0] !== 1'b0 || neg_a !== 1'b0 || ovf_a !== 1'b0 || used_a !== 4'd0) begin
            fails++;
            $display("FAIL reset_outputs: got dec=%h ov=%b neg=%b ovf=%b used=%0d, want all 0",
                     dec_a, out_valid[0], neg_a, ovf_a, used_a);
        end
        tests++;
        if (in_ready !== 3'b000) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 000", in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 3'b111) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 111", in_ready);
        end
    endtask

    task automatic test_max();
        int lat; logic [39:0] bcd; logic neg, ovf; logic [3:0] used;
        convert(0, 32'hFFFF_FFFF, lat, bcd, neg, ovf, used);
        tests++;
        if (lat !== 32) begin
            fails++;
            $display("FAIL max_latency: got %0d want 32", lat);
        end
        tests++;
        if (bcd !== 40'h42_9496_7295 || used !== 4'd10 || ovf !== 1'b0 || neg !== 1'b0) begin
            fails++;
            $display("FAIL max_value: got %h used=%0d ovf=%b neg=%b want 4294967295 used=10 ovf=0 neg=0",
                     bcd, used, ovf, neg);
        end
    endtask

    task automatic test_small_values();
        int lat; logic [39:0] bcd; logic neg, ovf; logic [3:0] used;
        convert(0, 32'd0, lat, bcd, neg, ovf, used);
        tests++;
        if (lat !== 32 || bcd !== 40'h0 || used !== 4'd1 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL zero_value: got lat=%0d %h used=%0d ovf=%b want lat=32 0 used=1 ovf=0",
                     lat, bcd, used, ovf);
        end
        convert(0, 32'd12345, lat, bcd, neg, ovf, used);
        tests++;
        if (lat !== 32 || bcd !== 40'h12345 || used !== 4'd5 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL value_12345: got lat=%0d %h used=%0d ovf=%b want lat=32 12345 used=5 ovf=0",
                     lat, bcd, used, ovf);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [39:0] bcd; logic neg, ovf; logic [3:0] used;
        convert(1, 32'd1000000, lat, bcd, neg, ovf, used);
        tests++;
        if (lat !== 32 || ovf !== 1'b1 || bcd !== 40'h999999) begin
            fails++;
            $display("FAIL overflow_sat: got lat=%0d ovf=%b %h want lat=32 ovf=1 999999", lat, ovf, bcd);
        end
        convert(1, 32'd999999, lat, bcd, neg, ovf, used);
        tests++;
        if (ovf !== 1'b0 || bcd !== 40'h999999 || used !== 4'd6) begin
            fails++;
            $display("FAIL overflow_clear: got ovf=%b %h used=%0d want ovf=0 999999 used=6", ovf, bcd, used);
        end
        convert(1, 32'd65536, lat, bcd, neg, ovf, used);
        tests++;
        if (ovf !== 1'b0 || bcd !== 40'h065536 || used !== 4'd5) begin
            fails++;
            $display("FAIL d6_65536: got ovf=%b %h used=%0d want ovf=0 65536 used=5", ovf, bcd, used);
        end
    endtask

    task automatic test_signed();
        int lat; logic [39:0] bcd; logic neg, ovf; logic [3:0] used;
        convert(2, 32'h0000_00FF, lat, bcd, neg, ovf, used);
        tests++;
        if (lat !== 8 || neg !== 1'b1 || bcd !== 40'h001 || used !== 4'd1 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL signed_ff: got lat=%0d neg=%b %h used=%0d ovf=%b want lat=8 neg=1 001 used=1 ovf=0",
                     lat, neg, bcd, used, ovf);
        end
        convert(2, 32'h0000_0080, lat, bcd, neg, ovf, used);
        tests++;
        if (neg !== 1'b1 || bcd !== 40'h128 || used !== 4'd3) begin
            fails++;
            $display("FAIL signed_80: got neg=%b %h used=%0d want neg=1 128 used=3", neg, bcd, used);
        end
        convert(2, 32'h0000_007F, lat, bcd, neg, ovf, used);
        tests++;
        if (neg !== 1'b0 || bcd !== 40'h127 || used !== 4'd3) begin
            fails++;
            $display("FAIL signed_7f: got neg=%b %h used=%0d want neg=0 127 used=3", neg, bcd, used);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [39:0] bcd; logic neg, ovf; logic [3:0] used;
        bit seen;
        out_ready[0] = 1'b0;
        convert(0, 32'd77, lat, bcd, neg, ovf, used);
        tests++;
        if (lat !== 32 || bcd !== 40'h77 || used !== 4'd2) begin
            fails++;
            $display("FAIL bp_result: got lat=%0d %h used=%0d want lat=32 77 used=2", lat, bcd, used);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || dec_a !== 40'h77 || used_a !== 4'd2) begin
                fails++;
                $display("FAIL bp_hold_%0d: got ov=%b ir=%b %h used=%0d want ov=1 ir=0 77 used=2",
                         i, out_valid[0], in_ready[0], dec_a, used_a);
            end
            bin_a       = 32'd999;
            in_valid[0] = 1'b1;
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", out_valid[0], in_ready[0]);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_accept: got outValid=%b during idle, want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [39:0] bcd; logic neg, ovf; logic [3:0] used;
        int n;
        bit seen;
        @(negedge clk);
        n = 0;
        while (!in_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        bin_a       = 32'd12345;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (dec_a !== 40'h0 || out_valid[0] !== 1'b0 || ovf_a !== 1'b0 || used_a !== 4'd0 || in_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h ov=%b ovf=%b used=%0d ir=%b want all 0",
                     dec_a, out_valid[0], ovf_a, used_a, in_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_valid: got outValid=%b after abort, want 0", seen);
        end
        convert(0, 32'd4321, lat, bcd, neg, ovf, used);
        tests++;
        if (lat !== 32 || bcd !== 40'h4321 || used !== 4'd4 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL midreset_recover: got lat=%0d %h used=%0d ovf=%b want lat=32 4321 used=4 ovf=0",
                     lat, bcd, used, ovf);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 3'b111;
        bin_a     = '0;
        bin_b     = '0;
        bin_c     = '0;
        test_reset();
        test_max();
        test_small_values();
        test_overflow();
        test_signed();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
